// File: rtl/otter_mem_arb_if.sv
// Bundles the fetch port, data port and memory bus of otter_mem_arb.
// slave is the arbiter's view; master is the requesters'/memory's view.
interface otter_mem_arb_if;
  // fetch port
  logic        IF_REQ;
  logic [31:0] IF_ADDR;
  logic        IF_VALID;
  logic [31:0] IF_DATA;

  // data port
  logic        D_REQ;
  logic        D_WE;
  logic [31:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic [1:0]  D_SIZE;
  logic        D_SIGN;
  logic        D_VALID;
  logic [31:0] D_RDATA;

  // memory bus
  logic        M_REQ;
  logic        M_WE;
  logic [31:0] M_ADDR;
  logic [31:0] M_WDATA;
  logic [1:0]  M_SIZE;
  logic        M_SIGN;
  logic        M_ACK;
  logic [31:0] M_RDATA;

  // pipeline stalls and error status
  logic        STALL_IF;
  logic        STALL_MEM;
  logic        ERR;
  logic        ERR_CLR;

  modport slave (
    input  IF_REQ, IF_ADDR,
    input  D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN,
    input  M_ACK, M_RDATA, ERR_CLR,
    output IF_VALID, IF_DATA, D_VALID, D_RDATA,
    output M_REQ, M_WE, M_ADDR, M_WDATA, M_SIZE, M_SIGN,
    output STALL_IF, STALL_MEM, ERR
  );

  modport master (
    output IF_REQ, IF_ADDR,
    output D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN,
    output M_ACK, M_RDATA, ERR_CLR,
    input  IF_VALID, IF_DATA, D_VALID, D_RDATA,
    input  M_REQ, M_WE, M_ADDR, M_WDATA, M_SIZE, M_SIGN,
    input  STALL_IF, STALL_MEM, ERR
  );
endinterface

// File: rtl/otter_mem_arb.sv
// Arbitrates the fetch and data ports onto one handshake memory bus, with a
// fetch starvation guard and a busy timeout that aborts and sets sticky ERR.
module otter_mem_arb #(
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 255
) (
  input  logic           CLK,
  input  logic           RESET_N,
  otter_mem_arb_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY  = 2'd2;

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int BW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BUSY_MAX   = BW'(TIMEOUT);

  logic [1:0]    state;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] busy_cnt;

  logic          m_req_q;
  logic          m_we_q;
  logic [31:0]   m_addr_q;
  logic [31:0]   m_wdata_q;
  logic [1:0]    m_size_q;
  logic          m_sign_q;
  logic          if_valid_q;
  logic [31:0]   if_data_q;
  logic          d_valid_q;
  logic [31:0]   d_rdata_q;
  logic          err_q;

  logic          grant_if;
  logic          grant_d;
  logic          busy;
  logic          done_ack;
  logic          done_to;
  logic          done;

  // Data has priority unless fetch has already waited through STARVE_LIMIT
  // consecutive data grants.
  // NOTE: every output of an always_comb gets a default first, so no path
  // through the block can leave a value held and infer a latch.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state == IDLE) begin
      if (bus.IF_REQ && (!bus.D_REQ || starve_cnt == STARVE_MAX)) begin
        grant_if = 1'b1;
      end else if (bus.D_REQ) begin
        grant_d = 1'b1;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign done_ack = busy && bus.M_ACK;
  assign done_to  = busy && !bus.M_ACK && (busy_cnt == BUSY_MAX);
  assign done     = done_ack || done_to;

  // NOTE: state registers use non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the datapath registers are reset as well because they are visible
  // on ports and must read zero immediately on reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      starve_cnt <= '0;
      busy_cnt   <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_size_q   <= '0;
      m_sign_q   <= 1'b0;
      if_valid_q <= 1'b0;
      if_data_q  <= '0;
      d_valid_q  <= 1'b0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_if) begin
            state      <= IF_BUSY;
            starve_cnt <= '0;
            busy_cnt   <= '0;
            m_req_q    <= 1'b1;
            m_we_q     <= 1'b0;
            m_addr_q   <= bus.IF_ADDR;
            m_wdata_q  <= '0;
            m_size_q   <= 2'b10;
            m_sign_q   <= 1'b0;
          end else if (grant_d) begin
            state     <= D_BUSY;
            busy_cnt  <= '0;
            m_req_q   <= 1'b1;
            m_we_q    <= bus.D_WE;
            m_addr_q  <= bus.D_ADDR;
            m_wdata_q <= bus.D_WDATA;
            m_size_q  <= bus.D_SIZE;
            m_sign_q  <= bus.D_SIGN;
            if (bus.IF_REQ && starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end

        IF_BUSY, D_BUSY: begin
          if (done) begin
            state   <= IDLE;
            m_req_q <= 1'b0;
            m_we_q  <= 1'b0;
            // A timed-out read returns zero; a write never touches D_RDATA.
            if (state == IF_BUSY) begin
              if_valid_q <= 1'b1;
              if_data_q  <= done_ack ? bus.M_RDATA : 32'h0;
            end else begin
              d_valid_q <= 1'b1;
              if (!m_we_q) begin
                d_rdata_q <= done_ack ? bus.M_RDATA : 32'h0;
              end
            end
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          m_req_q <= 1'b0;
          m_we_q  <= 1'b0;
        end
      endcase

      // A timeout on the same edge as ERR_CLR wins, so no abort is missed.
      if (done_to) begin
        err_q <= 1'b1;
      end else if (bus.ERR_CLR) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.M_REQ     = m_req_q;
  assign bus.M_WE      = m_we_q;
  assign bus.M_ADDR    = m_addr_q;
  assign bus.M_WDATA   = m_wdata_q;
  assign bus.M_SIZE    = m_size_q;
  assign bus.M_SIGN    = m_sign_q;
  assign bus.IF_VALID  = if_valid_q;
  assign bus.IF_DATA   = if_data_q;
  assign bus.D_VALID   = d_valid_q;
  assign bus.D_RDATA   = d_rdata_q;
  assign bus.ERR       = err_q;
  assign bus.STALL_IF  = bus.IF_REQ & ~if_valid_q;
  assign bus.STALL_MEM = bus.D_REQ & ~d_valid_q;

endmodule

// File: tb/tb_otter_mem_arb.sv
// Directed bench for otter_mem_arb: inputs change and outputs are sampled on
// the falling edge, memory acks are driven by hand inside each scenario.
module tb_otter_mem_arb;

  logic CLK;
  logic RESET_N;
  int   vectors     = 0;
  int   miscompares = 0;
  logic [31:0] exp_d_rdata = 32'h0;

  otter_mem_arb_if bus ();

  otter_mem_arb #(
    .STARVE_LIMIT(3),
    .TIMEOUT     (4)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    bus.IF_REQ = 1'b0; bus.IF_ADDR = '0;
    bus.D_REQ = 1'b0; bus.D_WE = 1'b0; bus.D_ADDR = '0; bus.D_WDATA = '0;
    bus.D_SIZE = '0; bus.D_SIGN = 1'b0;
    bus.M_ACK = 1'b0; bus.M_RDATA = '0; bus.ERR_CLR = 1'b0;
    cyc();
    bus.IF_REQ = 1'b1;
    cyc();
    vectors++; if (bus.M_REQ !== 1'b0) begin miscompares++; $display("FAIL reset_m_req: got %b want 0", bus.M_REQ); end
    vectors++; if (bus.M_ADDR !== 32'h0) begin miscompares++; $display("FAIL reset_m_addr: got %h want 0", bus.M_ADDR); end
    vectors++; if (bus.IF_VALID !== 1'b0 || bus.D_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b%b want 00", bus.IF_VALID, bus.D_VALID); end
    vectors++; if (bus.IF_DATA !== 32'h0 || bus.D_RDATA !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h/%h want 0/0", bus.IF_DATA, bus.D_RDATA); end
    vectors++; if (bus.ERR !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", bus.ERR); end
    vectors++; if (bus.STALL_IF !== 1'b1) begin miscompares++; $display("FAIL reset_stall_if: got %b want 1", bus.STALL_IF); end
    bus.IF_REQ = 1'b0;
    RESET_N = 1'b1;
    cyc();
  endtask

  // Single fetch with memory ack in the first M_REQ cycle.
  task automatic test_fetch();
    bus.IF_REQ = 1'b1; bus.IF_ADDR = 32'h100;
    cyc();
    vectors++; if (bus.M_REQ !== 1'b1) begin miscompares++; $display("FAIL fetch_m_req: got %b want 1", bus.M_REQ); end
    vectors++; if (bus.M_ADDR !== 32'h100) begin miscompares++; $display("FAIL fetch_m_addr: got %h want 100", bus.M_ADDR); end
    vectors++; if (bus.M_SIZE !== 2'b10 || bus.M_SIGN !== 1'b0 || bus.M_WE !== 1'b0) begin miscompares++; $display("FAIL fetch_attr: got size %b sign %b we %b want 10 0 0", bus.M_SIZE, bus.M_SIGN, bus.M_WE); end
    vectors++; if (bus.IF_VALID !== 1'b0 || bus.STALL_IF !== 1'b1) begin miscompares++; $display("FAIL fetch_early: got valid %b stall %b want 0 1", bus.IF_VALID, bus.STALL_IF); end
    bus.M_ACK = 1'b1; bus.M_RDATA = 32'h0000_0013;
    cyc();
    vectors++; if (bus.IF_VALID !== 1'b1 || bus.IF_DATA !== 32'h13) begin miscompares++; $display("FAIL fetch_done: got valid %b data %h want 1 13", bus.IF_VALID, bus.IF_DATA); end
    vectors++; if (bus.M_REQ !== 1'b0 || bus.STALL_IF !== 1'b0) begin miscompares++; $display("FAIL fetch_release: got m_req %b stall %b want 0 0", bus.M_REQ, bus.STALL_IF); end
    bus.IF_REQ = 1'b0; bus.M_ACK = 1'b0;
    cyc();
    vectors++; if (bus.IF_VALID !== 1'b0 || bus.IF_DATA !== 32'h13 || bus.M_REQ !== 1'b0) begin miscompares++; $display("FAIL fetch_after: got valid %b data %h m_req %b want 0 13 0", bus.IF_VALID, bus.IF_DATA, bus.M_REQ); end
  endtask

  // Fetch request held across VALID re-issues one cycle after the pulse.
  task automatic test_back_to_back();
    bus.IF_REQ = 1'b1; bus.IF_ADDR = 32'h200;
    cyc();
    bus.M_ACK = 1'b1; bus.M_RDATA = 32'h0000_000A;
    cyc();
    vectors++; if (bus.IF_VALID !== 1'b1 || bus.M_REQ !== 1'b0) begin miscompares++; $display("FAIL b2b_first: got valid %b m_req %b want 1 0", bus.IF_VALID, bus.M_REQ); end
    bus.M_ACK = 1'b0; bus.IF_ADDR = 32'h204;
    cyc();
    vectors++; if (bus.M_REQ !== 1'b1 || bus.M_ADDR !== 32'h204 || bus.IF_VALID !== 1'b0) begin miscompares++; $display("FAIL b2b_reissue: got m_req %b addr %h valid %b want 1 204 0", bus.M_REQ, bus.M_ADDR, bus.IF_VALID); end
    bus.M_ACK = 1'b1; bus.M_RDATA = 32'h0000_000B;
    cyc();
    vectors++; if (bus.IF_VALID !== 1'b1 || bus.IF_DATA !== 32'hB) begin miscompares++; $display("FAIL b2b_second: got valid %b data %h want 1 b", bus.IF_VALID, bus.IF_DATA); end
    bus.IF_REQ = 1'b0; bus.M_ACK = 1'b0;
    cyc();
  endtask

  // Both ports held with an immediate-ack memory: grants D,D,D,IF,D,D,D,IF.
  task automatic test_arbitration();
    logic        exp_fetch;
    logic [31:0] rd;
    bus.IF_REQ = 1'b1; bus.IF_ADDR = 32'h300;
    bus.D_REQ = 1'b1; bus.D_WE = 1'b0; bus.D_ADDR = 32'h4000;
    bus.D_SIZE = 2'b01; bus.D_SIGN = 1'b1;
    for (int g = 0; g < 8; g++) begin
      exp_fetch = (g % 4 == 3);
      rd = 32'hA000_0000 + 32'(g);
      cyc();
      vectors++; if (bus.M_REQ !== 1'b1 || bus.M_ADDR !== (exp_fetch ? 32'h300 : 32'h4000)) begin miscompares++; $display("FAIL arb_grant%0d: got m_req %b addr %h want 1 %h", g, bus.M_REQ, bus.M_ADDR, exp_fetch ? 32'h300 : 32'h4000); end
      vectors++; if (bus.M_SIZE !== (exp_fetch ? 2'b10 : 2'b01) || bus.M_SIGN !== !exp_fetch) begin miscompares++; $display("FAIL arb_attr%0d: got size %b sign %b", g, bus.M_SIZE, bus.M_SIGN); end
      vectors++; if (bus.STALL_IF !== 1'b1 || bus.STALL_MEM !== 1'b1) begin miscompares++; $display("FAIL arb_stall_busy%0d: got %b%b want 11", g, bus.STALL_IF, bus.STALL_MEM); end
      bus.M_ACK = 1'b1; bus.M_RDATA = rd;
      cyc();
      vectors++; if (bus.IF_VALID !== exp_fetch || bus.D_VALID !== !exp_fetch) begin miscompares++; $display("FAIL arb_valid%0d: got if %b d %b want %b %b", g, bus.IF_VALID, bus.D_VALID, exp_fetch, !exp_fetch); end
      if (exp_fetch) begin
        vectors++; if (bus.IF_DATA !== rd || bus.STALL_IF !== 1'b0) begin miscompares++; $display("FAIL arb_if_done%0d: got data %h stall %b want %h 0", g, bus.IF_DATA, bus.STALL_IF, rd); end
      end else begin
        exp_d_rdata = rd;
        vectors++; if (bus.D_RDATA !== rd || bus.STALL_IF !== 1'b1 || bus.STALL_MEM !== 1'b0) begin miscompares++; $display("FAIL arb_d_done%0d: got data %h stall_if %b stall_mem %b want %h 1 0", g, bus.D_RDATA, bus.STALL_IF, bus.STALL_MEM, rd); end
      end
      bus.M_ACK = 1'b0;
    end
    bus.IF_REQ = 1'b0; bus.D_REQ = 1'b0;
    cyc();
  endtask

  task automatic test_ack_idle();
    bus.M_ACK = 1'b1; bus.M_RDATA = 32'h1234_5678;
    cyc();
    vectors++; if (bus.IF_VALID !== 1'b0 || bus.D_VALID !== 1'b0 || bus.M_REQ !== 1'b0) begin miscompares++; $display("FAIL idle_ack_valid: got if %b d %b m_req %b want 0 0 0", bus.IF_VALID, bus.D_VALID, bus.M_REQ); end
    vectors++; if (bus.IF_DATA !== 32'hA000_0007 || bus.D_RDATA !== exp_d_rdata) begin miscompares++; $display("FAIL idle_ack_data: got %h/%h want a0000007/%h", bus.IF_DATA, bus.D_RDATA, exp_d_rdata); end
    bus.M_ACK = 1'b0;
    cyc();
  endtask

  // Write with three wait cycles; requester changes and drops REQ while busy.
  task automatic test_write();
    bus.D_REQ = 1'b1; bus.D_WE = 1'b1; bus.D_ADDR = 32'h2000;
    bus.D_WDATA = 32'hDEAD_BEEF; bus.D_SIZE = 2'b10; bus.D_SIGN = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      vectors++; if (bus.M_REQ !== 1'b1 || bus.M_WE !== 1'b1 || bus.M_ADDR !== 32'h2000 || bus.M_WDATA !== 32'hDEAD_BEEF || bus.M_SIZE !== 2'b10 || bus.D_VALID !== 1'b0) begin miscompares++; $display("FAIL write_hold%0d: got req %b we %b addr %h wdata %h size %b valid %b", c, bus.M_REQ, bus.M_WE, bus.M_ADDR, bus.M_WDATA, bus.M_SIZE, bus.D_VALID); end
      bus.D_ADDR = 32'h3000 + 32'(c); bus.D_WDATA = 32'h0;
    end
    bus.D_REQ = 1'b0;
    bus.M_ACK = 1'b1; bus.M_RDATA = 32'h5555_5555;
    cyc();
    vectors++; if (bus.D_VALID !== 1'b1 || bus.D_RDATA !== exp_d_rdata) begin miscompares++; $display("FAIL write_done: got valid %b rdata %h want 1 %h", bus.D_VALID, bus.D_RDATA, exp_d_rdata); end
    vectors++; if (bus.M_WE !== 1'b0 || bus.M_REQ !== 1'b0) begin miscompares++; $display("FAIL write_release: got we %b req %b want 0 0", bus.M_WE, bus.M_REQ); end
    bus.M_ACK = 1'b0;
    cyc();
    vectors++; if (bus.D_VALID !== 1'b0 || bus.M_REQ !== 1'b0) begin miscompares++; $display("FAIL write_once: got valid %b req %b want 0 0", bus.D_VALID, bus.M_REQ); end
  endtask

  // TIMEOUT=4: M_REQ stays up five cycles, then the abort edge pulses VALID.
  task automatic test_timeout();
    bus.IF_REQ = 1'b1; bus.IF_ADDR = 32'h500;
    for (int c = 0; c < 5; c++) begin
      cyc();
      vectors++; if (bus.M_REQ !== 1'b1 || bus.IF_VALID !== 1'b0 || bus.ERR !== 1'b0) begin miscompares++; $display("FAIL to_if_wait%0d: got req %b valid %b err %b want 1 0 0", c, bus.M_REQ, bus.IF_VALID, bus.ERR); end
    end
    bus.IF_REQ = 1'b0;
    cyc();
    vectors++; if (bus.IF_VALID !== 1'b1 || bus.IF_DATA !== 32'h0 || bus.ERR !== 1'b1 || bus.M_REQ !== 1'b0) begin miscompares++; $display("FAIL to_if_abort: got valid %b data %h err %b req %b want 1 0 1 0", bus.IF_VALID, bus.IF_DATA, bus.ERR, bus.M_REQ); end
    cyc();
    vectors++; if (bus.ERR !== 1'b1 || bus.IF_VALID !== 1'b0) begin miscompares++; $display("FAIL to_err_sticky: got err %b valid %b want 1 0", bus.ERR, bus.IF_VALID); end
    bus.ERR_CLR = 1'b1;
    cyc();
    vectors++; if (bus.ERR !== 1'b0) begin miscompares++; $display("FAIL to_err_clr: got %b want 0", bus.ERR); end

    // Data read timeout with ERR_CLR held: the abort edge still sets ERR.
    bus.D_REQ = 1'b1; bus.D_WE = 1'b0; bus.D_ADDR = 32'h600;
    for (int c = 0; c < 5; c++) begin
      cyc();
      vectors++; if (bus.M_REQ !== 1'b1 || bus.D_VALID !== 1'b0) begin miscompares++; $display("FAIL to_d_wait%0d: got req %b valid %b want 1 0", c, bus.M_REQ, bus.D_VALID); end
    end
    bus.D_REQ = 1'b0;
    cyc();
    vectors++; if (bus.D_VALID !== 1'b1 || bus.D_RDATA !== 32'h0 || bus.ERR !== 1'b1) begin miscompares++; $display("FAIL to_d_abort: got valid %b rdata %h err %b want 1 0 1", bus.D_VALID, bus.D_RDATA, bus.ERR); end
    bus.ERR_CLR = 1'b0;
    cyc();
    bus.ERR_CLR = 1'b1;
    cyc();
    vectors++; if (bus.ERR !== 1'b0) begin miscompares++; $display("FAIL to_err_clr2: got %b want 0", bus.ERR); end
    bus.ERR_CLR = 1'b0;
  endtask

  // Asynchronous reset during D_BUSY; a late ack must not produce D_VALID.
  task automatic test_reset_mid();
    bus.D_REQ = 1'b1; bus.D_WE = 1'b0; bus.D_ADDR = 32'h700; bus.D_SIZE = 2'b01;
    cyc();
    vectors++; if (bus.M_REQ !== 1'b1 || bus.M_ADDR !== 32'h700) begin miscompares++; $display("FAIL rst_mid_busy: got req %b addr %h want 1 700", bus.M_REQ, bus.M_ADDR); end
    bus.D_REQ = 1'b0;
    RESET_N = 1'b0;
    #1;
    vectors++; if (bus.M_REQ !== 1'b0 || bus.M_ADDR !== 32'h0 || bus.M_SIZE !== 2'b00) begin miscompares++; $display("FAIL rst_mid_async: got req %b addr %h size %b want 0 0 00", bus.M_REQ, bus.M_ADDR, bus.M_SIZE); end
    cyc();
    RESET_N = 1'b1;
    bus.M_ACK = 1'b1; bus.M_RDATA = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      cyc();
      vectors++; if (bus.D_VALID !== 1'b0 || bus.M_REQ !== 1'b0 || bus.D_RDATA !== 32'h0) begin miscompares++; $display("FAIL rst_mid_after%0d: got valid %b req %b rdata %h want 0 0 0", c, bus.D_VALID, bus.M_REQ, bus.D_RDATA); end
    end
    bus.M_ACK = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_back_to_back();
    test_arbitration();
    test_ack_idle();
    test_write();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/otter_mem_arb.md
OTTER_MEM_ARB -- requirements
Module: otter_mem_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 3, meaning the maximum number of consecutive data grants while a fetch request waits.
REQ-002 Parameter TIMEOUT, default 255, meaning the busy cycles without M_ACK before a transaction is aborted.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 CLK  in  1  clock; all state updates occur on its rising edge.
REQ-005 RESET_N  in  1  asynchronous active-low reset.
REQ-006 IF_REQ  in  1  fetch request, held until IF_VALID.
REQ-007 IF_ADDR  in  32  fetch address.
REQ-008 IF_VALID  out  1  one-cycle fetch completion pulse.
REQ-009 IF_DATA  out  32  fetch data, held until the next fetch completion.
REQ-010 D_REQ, D_WE  in  1 each  data request, held until D_VALID, and its write enable.
REQ-011 D_ADDR, D_WDATA  in  32 each  data address and store data.
REQ-012 D_SIZE, D_SIGN  in  2 and 1  access size and sign.
REQ-013 D_VALID  out  1  one-cycle data completion pulse.
REQ-014 D_RDATA  out  32  load data.
REQ-015 M_REQ, M_WE  out  1 each  registered memory request and write enable.
REQ-016 M_ADDR, M_WDATA  out  32 each  latched memory address and store data.
REQ-017 M_SIZE, M_SIGN  out  2 and 1  latched memory size and sign; a fetch drives 2'b10 and 0.
REQ-018 M_ACK  in  1  memory completion; M_RDATA is valid in the same cycle.
REQ-019 M_RDATA  in  32  memory read data.
REQ-020 STALL_IF, STALL_MEM  out  1 each  pipeline stall outputs.
REQ-021 ERR  out  1  sticky timeout flag.
REQ-022 ERR_CLR  in  1  synchronous clear for ERR.

Function
REQ-023 The FSM SHALL have exactly three states: IDLE, IF_BUSY, D_BUSY.
REQ-024 In IDLE with any request pending, the block SHALL latch the winner's address, data, WE, size and sign into the M_* outputs at the clock edge.
- The same edge sets M_REQ=1 and enters the matching BUSY state.
REQ-025 Arbitration SHALL give the data port priority.
- Exception: when IF_REQ=1 and the starve count equals STARVE_LIMIT, fetch wins.
REQ-026 The starve count SHALL behave as follows.
- Increments on each data grant made while IF_REQ=1.
- Clears on each fetch grant.
- Saturates at STARVE_LIMIT.
REQ-027 The latched M_* values SHALL NOT change while in a BUSY state.
- Requester input changes in a BUSY state SHALL be ignored.
REQ-028 When the block is in a BUSY state and M_ACK=1 at a clock edge, that edge SHALL do all of the following.
- Clear M_REQ and return to IDLE.
- Pulse the matching VALID for exactly one cycle.
- Register M_RDATA into IF_DATA, or into D_RDATA for a read.
REQ-029 On a write completion, D_RDATA SHALL keep its previous value.
REQ-030 A request still asserted during its VALID cycle SHALL be treated as a new request.
- The earliest issue is one cycle after VALID, so throughput is at most one transaction per 2 cycles.
REQ-031 With M_ACK asserted in the first M_REQ cycle, completion latency SHALL be 2 cycles from request sample to VALID.
REQ-032 A requester that drops REQ mid-transaction SHALL NOT abort the transaction; VALID still pulses.
REQ-033 STALL_IF SHALL equal IF_REQ & ~IF_VALID, and STALL_MEM SHALL equal D_REQ & ~D_VALID; both are combinational.
REQ-034 A busy counter SHALL clear on entry to a BUSY state and increment each BUSY cycle without M_ACK.
REQ-035 When the busy counter reaches TIMEOUT, the next edge SHALL do all of the following.
- Clear M_REQ and return to IDLE.
- Pulse the matching VALID with data 32'h0.
- Set ERR.
REQ-036 M_ACK received in IDLE SHALL be ignored.
REQ-037 ERR SHALL clear only on ERR_CLR=1 or reset; a timeout and ERR_CLR at the same edge leave ERR=1.

Reset
REQ-038 RESET_N=0 SHALL immediately force the following, including mid-transaction.
- State IDLE.
- M_REQ, M_WE, IF_VALID, D_VALID and ERR at 0.
- IF_DATA, D_RDATA and all M_* buses at 0.
- Starve and busy counters at 0.
REQ-039 A transaction interrupted by reset SHALL produce no VALID pulse after RESET_N returns to 1.

Verification
REQ-040 IF_REQ=1, IF_ADDR=0x100, M_ACK returned in the first M_REQ cycle with M_RDATA=0x00000013 -> M_ADDR=0x100, M_SIZE=2'b10; IF_VALID pulses 2 cycles after the request with IF_DATA=0x13.
REQ-041 IF_REQ and D_REQ both held with D_WE=0 and an immediate-ack memory -> grant order D,D,D,IF,D,D,D,IF; STALL_IF stays high until each IF_VALID.
REQ-042 D_REQ=1, D_WE=1, D_ADDR=0x2000, D_WDATA=0xDEADBEEF, D_SIZE=2'b10, M_ACK after 3 wait cycles -> M_WE=1 for 4 cycles, M_WDATA stable, D_VALID pulses once, D_RDATA unchanged.
REQ-043 M_ACK never asserted, TIMEOUT=4 -> IF_VALID pulses with IF_DATA=0 and ERR=1; ERR_CLR=1 for one cycle returns ERR to 0.
REQ-044 RESET_N=0 asserted during D_BUSY -> M_REQ=0 immediately, with no D_VALID after release.
REQ-045 IF_REQ held across an IF_VALID -> a second M_REQ issues 1 cycle after VALID.
